// File: rtl/mem_port_arbiter_if.sv
// Bundles the IFU, LSU and downstream memory handshakes of the memory-port arbiter.
// The slave modport is the arbiter's view; the master modport drives it from outside.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_rdata;
    logic              if_resp_err;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_wen;
    logic [DATA_W-1:0] ls_wdata;
    logic [2:0]        ls_memop;
    logic              ls_resp_valid;
    logic [DATA_W-1:0] ls_resp_rdata;
    logic              ls_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_memop;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_resp_valid, if_resp_rdata, if_resp_err,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_memop,
        output ls_req_ready, ls_resp_valid, ls_resp_rdata, ls_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_memop,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_resp_valid, if_resp_rdata, if_resp_err,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_memop,
        input  ls_req_ready, ls_resp_valid, ls_resp_rdata, ls_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_memop,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (master 0) and LSU (master 1),
// one transaction in flight, with a watchdog that turns a lost response into an error.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic M_IF = 1'b0;
    localparam logic M_LS = 1'b1;

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic              r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_req_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_memop;

    logic              r_resp_valid [2];
    logic [DATA_W-1:0] r_resp_rdata [2];
    logic              r_resp_err   [2];

    logic              w_idle;
    logic              w_grant_ls;
    logic              w_grant_if;
    logic              w_in_wait;
    logic              w_ack;
    logic              w_timeout;
    logic              w_resp_fire;
    logic [DATA_W-1:0] w_resp_data;

    // Grant depends only on state, request valids and last_grant: no mem_* input reaches req_ready.
    assign w_idle     = (r_state == S_IDLE);
    assign w_grant_ls = bus.ls_req_valid && (!bus.if_req_valid || (r_last_grant == M_IF));
    assign w_grant_if = bus.if_req_valid && !w_grant_ls;

    assign bus.if_req_ready = w_idle && w_grant_if;
    assign bus.ls_req_ready = w_idle && w_grant_ls;

    // A real response beats a timeout landing on the same cycle.
    assign w_in_wait   = (r_state == S_WAIT);
    assign w_ack       = w_in_wait && bus.mem_resp_valid;
    assign w_timeout   = w_in_wait && !bus.mem_resp_valid && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_resp_fire = w_ack || w_timeout;
    assign w_resp_data = (w_ack && !r_wen) ? bus.mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_last_grant    <= M_IF;
            r_owner         <= M_IF;
            r_cnt           <= '0;
            r_mem_req_valid <= 1'b0;
            r_addr          <= '0;
            r_wen           <= 1'b0;
            r_wdata         <= '0;
            r_memop         <= 3'b000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_if || w_grant_ls) begin
                        r_state         <= S_ISSUE;
                        r_mem_req_valid <= 1'b1;
                        r_owner         <= w_grant_ls ? M_LS : M_IF;
                        r_last_grant    <= w_grant_ls ? M_LS : M_IF;
                        if (w_grant_ls) begin
                            r_addr  <= bus.ls_addr;
                            r_wen   <= bus.ls_wen;
                            r_wdata <= bus.ls_wdata;
                            r_memop <= bus.ls_memop;
                        end else begin
                            r_addr  <= bus.if_addr;
                            r_wen   <= 1'b0;
                            r_wdata <= '0;
                            r_memop <= 3'b010;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_resp_fire) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Per-master response registers; data and err hold until that master's next response.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        always_ff @(posedge clk) begin
            if (rst) begin
                r_resp_valid[gi] <= 1'b0;
                r_resp_rdata[gi] <= '0;
                r_resp_err[gi]   <= 1'b0;
            end else begin
                r_resp_valid[gi] <= w_resp_fire && (r_owner == 1'(gi));
                if (w_resp_fire && (r_owner == 1'(gi))) begin
                    r_resp_rdata[gi] <= w_resp_data;
                    r_resp_err[gi]   <= w_timeout;
                end
            end
        end
    end

    assign bus.if_resp_valid = r_resp_valid[0];
    assign bus.if_resp_rdata = r_resp_rdata[0];
    assign bus.if_resp_err   = r_resp_err[0];
    assign bus.ls_resp_valid = r_resp_valid[1];
    assign bus.ls_resp_rdata = r_resp_rdata[1];
    assign bus.ls_resp_err   = r_resp_err[1];

    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wen       = r_wen;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_memop     = r_memop;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=8): single reads, contention order,
// stalled store, timeout, response/timeout collision and reset during WAIT.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge so registered outputs have settled.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.if_req_valid   = 1'b0;
        bus.if_addr        = '0;
        bus.ls_req_valid   = 1'b0;
        bus.ls_addr        = '0;
        bus.ls_wen         = 1'b0;
        bus.ls_wdata       = '0;
        bus.ls_memop       = 3'b000;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        repeat (3) cycle();

        chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_addr",      bus.mem_addr,           32'd0);
        chk("rst_if_resp_valid", 32'(bus.if_resp_valid), 32'd0);
        chk("rst_ls_resp_valid", 32'(bus.ls_resp_valid), 32'd0);
        rst = 1'b0;
        cycle();

        // 1. single IFU read
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h8000_0000;
        bus.mem_req_ready = 1'b1;
        #1;
        chk("t1_if_ready", 32'(bus.if_req_ready), 32'd1);
        chk("t1_ls_ready", 32'(bus.ls_req_ready), 32'd0);
        cycle();
        bus.if_req_valid = 1'b0;
        chk("t1_mem_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("t1_mem_addr",  bus.mem_addr,           32'h8000_0000);
        chk("t1_mem_wen",   32'(bus.mem_wen),       32'd0);
        chk("t1_mem_memop", 32'(bus.mem_memop),     32'd2);
        cycle();
        chk("t1_wait_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0010_0073;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("t1_if_resp_valid", 32'(bus.if_resp_valid), 32'd1);
        chk("t1_if_resp_rdata", bus.if_resp_rdata,       32'h0010_0073);
        chk("t1_if_resp_err",   32'(bus.if_resp_err),    32'd0);
        chk("t1_ls_resp_valid", 32'(bus.ls_resp_valid),  32'd0);
        cycle();
        chk("t1_if_resp_pulse", 32'(bus.if_resp_valid), 32'd0);
        chk("t1_if_rdata_hold", bus.if_resp_rdata,       32'h0010_0073);

        // 2. contention: LSU first, then IFU, then LSU
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_0004;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h0000_0100;
        bus.ls_wen       = 1'b0;
        bus.ls_memop     = 3'b100;
        #1;
        chk("t2a_ls_ready", 32'(bus.ls_req_ready), 32'd1);
        chk("t2a_if_ready", 32'(bus.if_req_ready), 32'd0);
        cycle();
        bus.ls_req_valid = 1'b0;
        #1;
        chk("t2a_issue_if_ready", 32'(bus.if_req_ready), 32'd0);
        chk("t2a_mem_addr",  bus.mem_addr,       32'h0000_0100);
        chk("t2a_mem_memop", 32'(bus.mem_memop), 32'd4);
        cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0011;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("t2a_ls_resp_valid", 32'(bus.ls_resp_valid), 32'd1);
        chk("t2a_ls_resp_rdata", bus.ls_resp_rdata,      32'h0000_0011);
        chk("t2a_if_resp_valid", 32'(bus.if_resp_valid), 32'd0);
        bus.ls_req_valid = 1'b1;
        #1;
        chk("t2b_if_ready", 32'(bus.if_req_ready), 32'd1);
        chk("t2b_ls_ready", 32'(bus.ls_req_ready), 32'd0);
        cycle();
        bus.if_req_valid = 1'b0;
        chk("t2b_mem_addr",  bus.mem_addr,       32'h8000_0004);
        chk("t2b_mem_memop", 32'(bus.mem_memop), 32'd2);
        cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0022;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("t2b_if_resp_rdata", bus.if_resp_rdata,      32'h0000_0022);
        chk("t2b_ls_resp_valid", 32'(bus.ls_resp_valid), 32'd0);
        bus.if_req_valid = 1'b1;
        #1;
        chk("t2c_ls_ready", 32'(bus.ls_req_ready), 32'd1);
        chk("t2c_if_ready", 32'(bus.if_req_ready), 32'd0);
        cycle();
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0033;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("t2c_ls_resp_rdata", bus.ls_resp_rdata, 32'h0000_0033);

        // 3. stalled LSU store
        bus.mem_req_ready = 1'b0;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 32'h8000_1000;
        bus.ls_wdata      = 32'hCAFE_BABE;
        bus.ls_memop      = 3'b010;
        bus.ls_wen        = 1'b1;
        cycle();
        bus.ls_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("t3_stall_addr",  bus.mem_addr,           32'h8000_1000);
            chk("t3_stall_wdata", bus.mem_wdata,          32'hCAFE_BABE);
            chk("t3_stall_wen",   32'(bus.mem_wen),       32'd1);
            cycle();
        end
        bus.mem_req_ready = 1'b1;
        cycle();
        chk("t3_wait_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hDEAD_BEEF;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("t3_ls_resp_valid", 32'(bus.ls_resp_valid), 32'd1);
        chk("t3_ls_resp_rdata", bus.ls_resp_rdata,      32'd0);
        chk("t3_ls_resp_err",   32'(bus.ls_resp_err),   32'd0);
        bus.ls_wen = 1'b0;

        // 4. timeout after 8 WAIT cycles, late ack dropped
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_2000;
        cycle();
        bus.if_req_valid = 1'b0;
        cycle();
        for (int i = 0; i < 8; i++) begin
            chk("t4_no_early_resp", 32'(bus.if_resp_valid), 32'd0);
            cycle();
        end
        chk("t4_to_valid", 32'(bus.if_resp_valid), 32'd1);
        chk("t4_to_err",   32'(bus.if_resp_err),   32'd1);
        chk("t4_to_rdata", bus.if_resp_rdata,      32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0055;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("t4_late_ack_if", 32'(bus.if_resp_valid), 32'd0);
        chk("t4_late_ack_ls", 32'(bus.ls_resp_valid), 32'd0);
        chk("t4_err_hold",    32'(bus.if_resp_err),   32'd1);

        // 5. response collides with the final WAIT cycle
        bus.if_req_valid = 1'b1;
        cycle();
        bus.if_req_valid = 1'b0;
        cycle();
        for (int i = 0; i < 7; i++) begin
            chk("t5_no_early_resp", 32'(bus.if_resp_valid), 32'd0);
            cycle();
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1234_5678;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("t5_valid", 32'(bus.if_resp_valid), 32'd1);
        chk("t5_err",   32'(bus.if_resp_err),   32'd0);
        chk("t5_rdata", bus.if_resp_rdata,      32'h1234_5678);
        cycle();
        chk("t5_single_pulse", 32'(bus.if_resp_valid), 32'd0);

        // 6. reset while in WAIT, then contention grants LSU first
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h8000_3000;
        bus.ls_wdata     = 32'h0BAD_F00D;
        bus.ls_memop     = 3'b001;
        cycle();
        bus.ls_req_valid = 1'b0;
        cycle();
        rst = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h7777_7777;
        cycle();
        rst = 1'b0;
        bus.mem_resp_valid = 1'b0;
        chk("t6_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("t6_mem_addr",      bus.mem_addr,           32'd0);
        chk("t6_mem_wdata",     bus.mem_wdata,          32'd0);
        chk("t6_mem_memop",     32'(bus.mem_memop),     32'd0);
        chk("t6_ls_resp_valid", 32'(bus.ls_resp_valid), 32'd0);
        chk("t6_ls_resp_rdata", bus.ls_resp_rdata,      32'd0);
        chk("t6_if_resp_rdata", bus.if_resp_rdata,      32'd0);
        cycle();
        chk("t6_no_resp_after", 32'(bus.ls_resp_valid), 32'd0);
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        #1;
        chk("t6_ls_ready", 32'(bus.ls_req_ready), 32'd1);
        chk("t6_if_ready", 32'(bus.if_req_ready), 32'd0);
        cycle();
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        chk("t6_mem_addr_grant", bus.mem_addr, 32'h8000_3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between the instruction-fetch requester (master 0, IFU) and the load/store requester (master 1, LSU).
- Runs a valid/ready request handshake on each master side and on the downstream memory side.
- Keeps at most one transaction outstanding, grants round-robin under contention, and routes each response back to the master that issued it.
- Includes a watchdog counter that converts a missing downstream response into an error response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 256, max cycles spent in WAIT before an error response is generated (must be >= 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req_valid  in  1  IFU request valid
if_req_ready  out  1  IFU request accepted this cycle
if_addr  in  ADDR_W  IFU fetch address (read only)
if_resp_valid  out  1  IFU response pulse
if_resp_rdata  out  DATA_W  IFU read data
if_resp_err  out  1  IFU response is a timeout
ls_req_valid  in  1  LSU request valid
ls_req_ready  out  1  LSU request accepted this cycle
ls_addr  in  ADDR_W  LSU address
ls_wen  in  1  LSU write enable
ls_wdata  in  DATA_W  LSU write data
ls_memop  in  3  LSU access size/sign code, passed through unchanged
ls_resp_valid  out  1  LSU response pulse
ls_resp_rdata  out  DATA_W  LSU read data
ls_resp_err  out  1  LSU response is a timeout
mem_req_valid  out  1  downstream request valid
mem_req_ready  in  1  downstream accepts request
mem_addr  out  ADDR_W  downstream address
mem_wen  out  1  downstream write enable
mem_wdata  out  DATA_W  downstream write data
mem_memop  out  3  downstream access code
mem_resp_valid  in  1  downstream response/ack
mem_rdata  in  DATA_W  downstream read data

Behaviour:

Clock and reset:
- One clock; reset is synchronous and active-high (clk, rst).
- On rst, regardless of state:
  - state=IDLE, last_grant=IFU, watchdog counter=0.
  - All registered outputs are 0 (all resp_valid/rdata/err, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_memop).
  - An in-flight transaction is abandoned with no response to either master.

States: IDLE, ISSUE, WAIT.

IDLE:
- req_ready is asserted combinationally, only in IDLE, only to the granted master, and only when that master's req_valid=1.
- Grant rules:
  - Only one master valid: grant that master.
  - Both valid: grant the master that is not last_grant.
- On grant:
  - Latch addr/wen/wdata/memop. An IFU request is latched as wen=0, wdata=0, memop=3'b010 (word).
  - Store the owner, update last_grant, go to ISSUE.
- No valid request: remain in IDLE.

ISSUE:
- mem_req_valid=1 with the latched fields held stable.
- On mem_req_ready=1: clear the counter, go to WAIT.
- A stall of any length is allowed; no timeout applies in ISSUE.

WAIT:
- mem_req_valid=0; the counter increments each cycle.
- mem_resp_valid=1: next cycle, the owner's resp_valid=1 for exactly one cycle.
  - resp_rdata = mem_rdata for reads, 0 for writes; resp_err=0.
  - Go to IDLE.
- Counter reaches TIMEOUT-1 with no response: the owner gets resp_valid=1, resp_err=1, resp_rdata=0; go to IDLE.
- Response and timeout in the same cycle: the response wins and err=0.

Response outputs:
- resp_rdata/err hold their value until the next response to the same master.
- resp_valid of the non-owner is never asserted.
- mem_resp_valid is ignored outside WAIT, so a late ack after a timeout is dropped.

Latency:
- Request accepted at cycle T → mem_req_valid at T+1 → (ready at T+1) WAIT at T+2 → earliest resp_valid at T+3.
- A new request may be accepted in the same cycle the previous resp_valid is high, because the block is back in IDLE.

Constraints:
- Masters hold their request stable until req_ready.
- No combinational path from any mem_* input to any req_ready.

Test Plan:
1. Single IFU read: if_req_valid, if_addr=0x80000000; mem ready immediately; mem_resp_valid with mem_rdata=0x00100073 two cycles later → mem_addr=0x80000000, mem_wen=0, mem_memop=3'b010; if_resp_valid pulses one cycle with rdata=0x00100073; ls_resp_valid stays 0.
2. Contention after reset: both valid in the same cycle → LSU granted first (ls_req_ready=1, if_req_ready=0). The IFU, still valid, is granted next; third contention → LSU again.
3. LSU store: ls_addr=0x80001000, ls_wdata=0xCAFEBABE, ls_memop=3'b010, wen=1; mem_req_ready held low for 5 cycles → mem_req_valid and fields stable for all 5 cycles; after the ack, ls_resp_valid=1, rdata=0, err=0.
4. Timeout with TIMEOUT=8: accepted, never acked → the owner gets resp_valid with err=1 exactly 8 WAIT cycles after entering WAIT. A mem_resp_valid one cycle later is ignored (no second pulse).
5. Response and timeout collide on the final WAIT cycle → err=0, rdata=mem_rdata, single pulse.
6. rst asserted during WAIT → next cycle all outputs 0, state IDLE, no resp_valid. After deassert, simultaneous requests grant LSU first.
